// File: rtl/rtype_encoder_if.sv
// Request/instruction-memory bundle for rtype_encoder.
// The slave modport is the encoder's view: it takes ALU operation requests
// and drives the instruction-memory write port. The master modport is the
// loader/memory side.
interface rtype_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_alu_control;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, in_alu_control, in_rd, in_rs1, in_rs2, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_alu_control, in_rd, in_rs1, in_rs2, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rtype_encoder.sv
// rtype_encoder: turns ALU-control requests into RV32I R-type instruction
// words and writes them sequentially into instruction memory.
// Optional feature macro: RTYPE_ENC_ERRCNT_EN. When defined, err_count
// counts dropped invalid codes (saturating at 255). Otherwise it reads 0.
module rtype_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  rtype_encoder_if.slave    bus,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              last_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  word_count_reg;
  logic              err_reg;

  logic              code_ok;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [31:0]       enc_word;
  logic              in_ready;

  // Translate the ALU control code back into its func3/func7 pair.
  always_comb begin
    code_ok = 1'b1;
    func3   = 3'd0;
    func7   = 7'h00;
    case (bus.in_alu_control)
      4'b0100: func3 = 3'd0;                       // ADD
      4'b0101: begin func3 = 3'd0; func7 = 7'h20; end // SUB
      4'b0001: func3 = 3'd1;                       // SLL
      4'b1010: func3 = 3'd2;                       // SLT
      4'b1001: func3 = 3'd3;                       // SLTU
      4'b1000: func3 = 3'd4;                       // XOR
      4'b0010: func3 = 3'd5;                       // SRL
      4'b0011: begin func3 = 3'd5; func7 = 7'h20; end // SRA
      4'b0111: func3 = 3'd6;                       // OR
      4'b0110: func3 = 3'd7;                       // AND
      default: code_ok = 1'b0;
    endcase
  end

  assign enc_word = {func7, bus.in_rs2, bus.in_rs1, func3, bus.in_rd, 7'b0110011};

  // A start pulse takes priority over a request in the same cycle, so the
  // request is simply not accepted; the handshake also stays low in reset.
  assign in_ready = (state_reg == IDLE) && !start && !rst;

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_reg;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign busy           = (state_reg == WRITE);
  assign done           = done_reg;
  assign word_count     = word_count_reg;
  assign err            = err_reg;

`ifdef RTYPE_ENC_ERRCNT_EN
  logic [7:0] err_count_reg;

  // Saturating count of dropped invalid codes, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= 8'd0;
    end else if (state_reg == IDLE && start) begin
      err_count_reg <= 8'd0;
    end else if (in_ready && bus.in_valid && !code_ok && err_count_reg != 8'hFF) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`else
  assign err_count = 8'd0;
`endif

  // Main FSM: IDLE accepts requests, WRITE holds the strobe until memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      last_reg       <= 1'b0;
      done_reg       <= 1'b0;
      word_count_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Word-align the base by clearing the two low address bits.
            addr_reg       <= base_addr & ~ADDR_W'(3);
            word_count_reg <= '0;
            err_reg        <= 1'b0;
          end else if (bus.in_valid) begin
            if (code_ok) begin
              wdata_reg <= enc_word;
              last_reg  <= bus.in_last;
              we_reg    <= 1'b1;
              state_reg <= WRITE;
            end else begin
              // Invalid code: consume it, flag it, but still end the program
              // if it was marked last.
              err_reg  <= 1'b1;
              done_reg <= bus.in_last;
            end
          end
        end
        WRITE: begin
          if (bus.imem_ready) begin
            addr_reg       <= addr_reg + ADDR_W'(4);
            word_count_reg <= word_count_reg + CNT_W'(1);
            we_reg         <= 1'b0;
            done_reg       <= last_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_encoder.sv
// Testbench for rtype_encoder: directed scenarios plus randomized requests,
// checked by a write scoreboard fed from a spec-level reference model.
module tb_rtype_encoder;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_count;
  logic              err;
  logic [7:0]        err_count;

  rtype_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  rtype_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int rdy_mode = 1;          // 0: hold low, 1: hold high, 2: random

  // Reference model state
  logic [31:0] m_addr = 32'd0;
  int          m_wc = 0;
  bit          m_err = 0;
  int          m_errcnt = 0;
  int          m_done = 0;

  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Spec-level encoding: look up func3/func7 by mnemonic, then assemble
  // the word by placing each field at its bit offset.
  function automatic logic [32:0] ref_encode(input logic [3:0] code, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2);
    longint f3 = 0;
    longint f7 = 0;
    bit     ok = 1'b1;
    longint w;
    case (code)
      4'd4:  begin f3 = 0; f7 = 0;    end // ADD
      4'd5:  begin f3 = 0; f7 = 32;   end // SUB
      4'd1:  begin f3 = 1; f7 = 0;    end // SLL
      4'd10: begin f3 = 2; f7 = 0;    end // SLT
      4'd9:  begin f3 = 3; f7 = 0;    end // SLTU
      4'd8:  begin f3 = 4; f7 = 0;    end // XOR
      4'd2:  begin f3 = 5; f7 = 0;    end // SRL
      4'd3:  begin f3 = 5; f7 = 32;   end // SRA
      4'd7:  begin f3 = 6; f7 = 0;    end // OR
      4'd6:  begin f3 = 7; f7 = 0;    end // AND
      default: ok = 1'b0;
    endcase
    w = f7 * 33554432 + longint'(rs2) * 1048576 + longint'(rs1) * 32768
      + f3 * 4096 + longint'(rd) * 128 + 51;
    return {ok, w[31:0]};
  endfunction

  // imem_ready generator, updated just after each rising edge.
  initial begin
    bus.imem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.imem_ready = 1'b0;
        1:       bus.imem_ready = 1'b1;
        default: bus.imem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every completed write, counts done pulses.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (bus.imem_we && bus.imem_ready && !rst) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h want no write", bus.imem_addr, bus.imem_wdata);
        end else begin
          e = sb_q.pop_front();
          $display("write addr=%h data=%h (expected addr=%h data=%h)", bus.imem_addr, bus.imem_wdata, e.addr, e.data);
          check("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.imem_wdata), 64'(e.data));
          last_addr = bus.imem_addr;
          last_data = bus.imem_wdata;
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_addr = b & ~32'd3;
    m_wc = 0;
    m_err = 0;
    m_errcnt = 0;
  endtask

  task automatic send(input logic [3:0] code, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic last);
    int n = 0;
    logic [32:0] r;
    wr_t e;
    bus.in_valid = 1'b1;
    bus.in_alu_control = code;
    bus.in_rd = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_last = last;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
      bus.in_valid = 1'b0;
    end else begin
      r = ref_encode(code, rd, rs1, rs2);
      if (r[32]) begin
        e.addr = m_addr;
        e.data = r[31:0];
        sb_q.push_back(e);
        m_addr = m_addr + 32'd4;
        m_wc++;
      end else begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
      if (last) m_done++;
      $display("request code=%b rd=%0d rs1=%0d rs2=%0d last=%0b", code, rd, rs1, rs2, last);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || bus.imem_we) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got pending=%0d want 0", sb_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int exp_errcnt();
`ifdef RTYPE_ENC_ERRCNT_EN
    return m_errcnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_word_count"}, 64'(word_count), 64'(m_wc % 65536));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_errcnt()));
    check({tag, "_done_count"}, 64'(done_seen), 64'(m_done));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_alu_control = 4'd0;
    bus.in_rd = 5'd0;
    bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0;
    bus.in_last = 1'b0;

    // Reset and reset values
    repeat (3) @(negedge clk);
    check("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_imem_we", 64'(bus.imem_we), 64'(0));
    check("rst_imem_addr", 64'(bus.imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(bus.imem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));

    // Single ADD at 0x100
    rdy_mode = 1;
    do_start(32'h100);
    send(4'b0100, 5'd1, 5'd2, 5'd3, 1'b0);
    wait_idle();
    check("add_addr", 64'(last_addr), 64'h100);
    check("add_data", 64'(last_data), 64'h003100B3);
    check_status("add");

    // SUB then SRA with last
    do_start(32'h100);
    send(4'b0101, 5'd5, 5'd6, 5'd7, 1'b0);
    send(4'b0011, 5'd1, 5'd1, 5'd2, 1'b1);
    wait_idle();
    check("sra_addr", 64'(last_addr), 64'h104);
    check("sra_data", 64'(last_data), 64'h4020D0B3);
    check_status("subsra");

    // Stalled write: outputs stable, in_ready low, in_valid and start ignored
    rdy_mode = 0;
    send(4'b0111, 5'd9, 5'd10, 5'd11, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_alu_control = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_we", 64'(bus.imem_we), 64'(1));
      check("stall_addr", 64'(bus.imem_addr), 64'(sb_q[0].addr));
      check("stall_wdata", 64'(bus.imem_wdata), 64'(sb_q[0].data));
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      if (i == 2) begin start = 1'b1; base_addr = 32'h800; end
      if (i == 3) start = 1'b0;
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    wait_idle();
    send(4'b1000, 5'd2, 5'd3, 5'd4, 1'b0);
    wait_idle();
    check_status("stall");

    // Invalid code then AND
    do_start(32'h200);
    send(4'b1111, 5'd1, 5'd1, 5'd1, 1'b0);
    send(4'b0110, 5'd3, 5'd4, 5'd5, 1'b0);
    wait_idle();
    check("and_addr", 64'(last_addr), 64'h200);
    check("and_data", 64'(last_data), 64'h005271B3);
    check("inv_err", 64'(err), 64'(1));
    check_status("inv");

    // Invalid code carrying last still pulses done
    send(4'b0000, 5'd0, 5'd0, 5'd0, 1'b1);
    wait_idle();
    check_status("invlast");

    // Address wrap
    do_start(32'hFFFF_FFFE);
    send(4'b0001, 5'd7, 5'd8, 5'd9, 1'b0);
    send(4'b1010, 5'd10, 5'd11, 5'd12, 1'b0);
    wait_idle();
    check("wrap_addr", 64'(last_addr), 64'h0);
    check_status("wrap");

    // start and in_valid together: request not accepted
    start = 1'b1;
    base_addr = 32'h300;
    bus.in_valid = 1'b1;
    bus.in_alu_control = 4'b1111;
    bus.in_last = 1'b0;
    @(negedge clk);
    check("start_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    m_addr = 32'h300; m_wc = 0; m_err = 0; m_errcnt = 0;
    repeat (3) @(negedge clk);
    check_status("startvalid");

    // Randomized traffic with random memory back-pressure
    rdy_mode = 2;
    for (int k = 0; k < 150; k++) begin
      send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check_status("random");

    // Reset during a stalled write
    rdy_mode = 0;
    send(4'b0010, 5'd4, 5'd5, 5'd6, 1'b0);
    @(negedge clk);
    check("pre_rst_we", 64'(bus.imem_we), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst_we", 64'(bus.imem_we), 64'(0));
    check("midrst_addr", 64'(bus.imem_addr), 64'(0));
    check("midrst_wdata", 64'(bus.imem_wdata), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    sb_q.delete();
    m_addr = 32'd0; m_wc = 0; m_err = 0; m_errcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check_status("postrst");
    send(4'b0100, 5'd1, 5'd1, 5'd1, 1'b0);
    wait_idle();
    check("post_rst_addr", 64'(last_addr), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/rtype_encoder.md
# rtype_encoder

Inverse of the core's R-type control decode. Accepts ALU operation requests (4-bit ALU control code plus register indices), encodes each into a 32-bit RV32I R-type instruction word, and writes the words sequentially into instruction memory through a ready-qualified write port. Used by the test/boot program loader to build instruction streams that the decode path later consumes.

## Interface
- ADDR_W, 32, instruction-memory byte-address width
- CNT_W, 16, width of written-word counter
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  pulse: load write pointer from base_addr, clear counters/flags
- base_addr  input  ADDR_W  first write address; bits [1:0] ignored (forced 0)
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept request
- in_alu_control  input  4  ALU operation code
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_last  input  1  marks final request of a program
- imem_we  output  1  write strobe
- imem_addr  output  ADDR_W  write byte address
- imem_wdata  output  32  encoded instruction
- imem_ready  input  1  memory accepts write this cycle
- busy  output  1  in WRITE state
- done  output  1  one-cycle pulse after last word written
- word_count  output  CNT_W  words written since start
- err  output  1  sticky: invalid code seen since start
- err_count  output  8  invalid codes dropped (see Configuration)

## Operation
- Encoding: wdata = {func7, rs2, rs1, func3, rd, 7'b0110011}.
- Code map (code: func3, func7): 0100 ADD 0,0x00; 0101 SUB 0,0x20; 0001 SLL 1,0x00; 1010 SLT 2,0x00; 1001 SLTU 3,0x00; 1000 XOR 4,0x00; 0010 SRL 5,0x00; 0011 SRA 5,0x20; 0111 OR 6,0x00; 0110 AND 7,0x00.
- Codes 0000, 1011–1111 invalid: request accepted (handshake completes), no write, err set, err_count incremented (saturates at 255), pointer unchanged. If in_last also set, done still pulses next cycle.
- FSM: IDLE, WRITE.
  - IDLE: in_ready=1. On in_valid with valid code: register wdata, go WRITE. Invalid code: stay IDLE.
  - WRITE: in_ready=0, imem_we=1, imem_addr/wdata stable. On imem_ready: addr += 4 (wraps modulo 2^ADDR_W), word_count += 1 (wraps), return IDLE; pulse done if the word carried in_last.
- start in IDLE: addr <= {base_addr[ADDR_W-1:2],2'b00}, word_count/err/err_count cleared; a request presented the same cycle is not accepted (in_ready forced 0 that cycle).
- start in WRITE: ignored; current write completes.
- Reset values: state IDLE, in_ready 1 (deasserted while rst high), imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, word_count 0, err 0, err_count 0.
- Reset mid-WRITE: write abandoned, no further strobe.

## Timing
- Accept at edge N → imem_we high from cycle N+1 until cycle with imem_ready=1 (inclusive).
- imem_ready high in first WRITE cycle: write completes in 1 cycle; in_ready high again cycle N+2. Peak throughput 1 word / 2 cycles.
- done asserted exactly one cycle, the cycle after the completing imem_ready edge.
- word_count/addr update on the same edge that completes the write.

## Configuration
- RTYPE_ENC_ERRCNT_EN defined: err_count implemented as above.
- Undefined: err_count tied to 0; err and drop behaviour unchanged.

## Test plan
- rst, start base_addr=0x100, ADD rd=1 rs1=2 rs2=3, imem_ready=1 → one strobe, addr 0x100, wdata 0x003100B3, word_count 1.
- SUB rd=5 rs1=6 rs2=7 then SRA rd=1 rs1=1 rs2=2 with in_last, imem_ready=1 → 0x407302B3 at 0x100, 0x4020D0B3 at 0x104, done pulse once.
- imem_ready held low 5 cycles in WRITE → imem_we/addr/wdata stable 6 cycles, in_ready 0, in_valid ignored.
- Code 1111 then code 0110 rd=3 rs1=4 rs2=5 → no write for first, err=1, err_count=1 (0 without macro); AND word 0x005271B3 at base.
- base_addr=0xFFFFFFFC, two valid requests → second write at 0x00000000.
- rst asserted during WRITE → imem_we drops immediately, all outputs at reset values.
